// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock, carrying between cycles.
// Define ADDER_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] next_w;
  logic [KW-1:0]    k;
  logic             carry;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // One narrow CHUNK-bit adder, steered to the current chunk by k.
  always_comb begin
    chunk_sum = {1'b0, a_reg[k*CHUNK +: CHUNK]} + {1'b0, b_reg[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    next_w = w;
    next_w[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      w     <= '0;
      k     <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        // DONE shares IDLE's acceptance path so back-to-back starts lose no cycle.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= cin_eff;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= chunk_sum[CHUNK];
          w     <= next_w;
          if (k == K_LAST) begin
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= next_w;
            cout  <= chunk_sum[CHUNK];
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (next_w[WIDTH-1] != a_reg[WIDTH-1]);
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: an 8/4 instance and a 4/1 instance on one clock.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
`ifdef ADDER_SUB_EN
  logic       sub8;
  logic       sub4;
`endif

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef ADDER_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for a w-bit adder (w = 8 or 4), operands held in the low bits.
  function automatic exp_t model(input int w, input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tcin, input logic tsub);
    logic [8:0] full;
    logic [7:0] mask, bb, aa;
    exp_t e;
    mask = (w == 8) ? 8'hFF : 8'h0F;
    aa   = ta & mask;
    bb   = (tsub ? ~tb : tb) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {8'b0, (tsub ? 1'b1 : tcin)};
    e.sum  = full[7:0] & mask;
    e.cout = (w == 8) ? full[8] : full[4];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin, input logic tsub);
    a8 = ta; b8 = tb; cin8 = tcin; start8 = 1'b1;
`ifdef ADDER_SUB_EN
    sub8 = tsub;
`endif
    q8.push_back(model(8, ta, tb, tcin, tsub));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] ta, input logic [3:0] tb, input logic tcin);
    a4 = ta; b4 = tb; cin4 = tcin; start4 = 1'b1;
    q4.push_back(model(4, {4'b0, ta}, {4'b0, tb}, tcin, 1'b0));
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done8 && n < 20);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done4 && n < 20);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_err++;
      $display("[TB] FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    n_cmp++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset4: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy4, done4, sum4, cout4, ovf4);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [7:0] ta [4] = '{8'h03, 8'hFF, 8'h7F, 8'hA5};
    logic [7:0] tb [4] = '{8'h0B, 8'h01, 8'h01, 8'h3C};
    logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    int   n;
    logic [7:0] held;
    for (int i = 0; i < 4; i++) begin
      issue8(ta[i], tb[i], tc[i], 1'b0);
      n_cmp++;
      if (busy8 !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL add_busy[%0d]: busy=%b expected 1", i, busy8);
      end
      wait_done8(n);
      n_cmp++;
      if (done8 !== 1'b1 || n != 2) begin
        n_err++;
        $display("[TB] FAIL add_latency[%0d]: done=%b after %0d edges, expected done=1 after 2", i, done8, n);
      end
      e = q8.pop_front();
      n_cmp++;
      if ({sum8, cout8, ovf8} !== {e.sum, e.cout, e.ovf}) begin
        n_err++;
        $display("[TB] FAIL add_result[%0d]: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum8, cout8, ovf8, e.sum, e.cout, e.ovf);
      end
      held = sum8;
      @(posedge clk); #1;
      n_cmp++;
      if (done8 !== 1'b0 || sum8 !== e.sum) begin
        n_err++;
        $display("[TB] FAIL add_pulse[%0d]: done=%b sum=%h expected done=0 sum=%h (was %h)",
                 i, done8, sum8, e.sum, held);
      end
    end
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub;
    logic [7:0] ta [2] = '{8'h05, 8'h80};
    logic [7:0] tb [2] = '{8'h07, 8'h01};
    exp_t e;
    int   n;
    for (int i = 0; i < 2; i++) begin
      issue8(ta[i], tb[i], 1'b0, 1'b1);
      sub8 = 1'b0;
      wait_done8(n);
      e = q8.pop_front();
      n_cmp++;
      if (done8 !== 1'b1 || {sum8, cout8, ovf8} !== {e.sum, e.cout, e.ovf}) begin
        n_err++;
        $display("[TB] FAIL sub[%0d]: done=%b sum=%h cout=%b ovf=%b expected done=1 sum=%h cout=%b ovf=%b",
                 i, done8, sum8, cout8, ovf8, e.sum, e.cout, e.ovf);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_ignore_start;
    exp_t e;
    int   n;
    int   pulses;
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(n);
    e = q8.pop_front();
    n_cmp++;
    if (done8 !== 1'b1 || n != 1 || {sum8, cout8, ovf8} !== {e.sum, e.cout, e.ovf}) begin
      n_err++;
      $display("[TB] FAIL ignore_result: done=%b edges=%0d sum=%h cout=%b ovf=%b expected done=1 edges=1 sum=%h cout=%b ovf=%b",
               done8, n, sum8, cout8, ovf8, e.sum, e.cout, e.ovf);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("[TB] FAIL ignore_queued: %0d busy/done cycles after completion, expected 0", pulses);
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int   n;
    issue8(8'hC0, 8'hC1, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q8.pop_back());
    n_cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      n_err++;
      $display("[TB] FAIL abort_state: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL abort_nodone: done=%b busy=%b expected 0 0", done8, busy8);
    end
    issue8(8'h03, 8'h0B, 1'b0, 1'b0);
    wait_done8(n);
    e = q8.pop_front();
    n_cmp++;
    if (done8 !== 1'b1 || n != 2 || {sum8, cout8, ovf8} !== {e.sum, e.cout, e.ovf}) begin
      n_err++;
      $display("[TB] FAIL abort_recover: done=%b edges=%0d sum=%h cout=%b ovf=%b expected done=1 edges=2 sum=%h cout=%b ovf=%b",
               done8, n, sum8, cout8, ovf8, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n;
    issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      wait_done8(n);
      n_cmp++;
      if (done8 !== 1'b1 || n != 2) begin
        n_err++;
        $display("[TB] FAIL b2b_latency[%0d]: done=%b after %0d edges, expected done=1 after 2", i, done8, n);
      end
      e = q8.pop_front();
      n_cmp++;
      if ({sum8, cout8, ovf8} !== {e.sum, e.cout, e.ovf}) begin
        n_err++;
        $display("[TB] FAIL b2b_result[%0d]: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum8, cout8, ovf8, e.sum, e.cout, e.ovf);
      end
      if (i < 5) begin
        issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        n_cmp++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL b2b_accept[%0d]: done=%b busy=%b expected 0 1", i, done8, busy8);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_chunk1;
    logic [3:0] ta [3] = '{4'b0011, 4'h7, 4'hF};
    logic [3:0] tb [3] = '{4'b1011, 4'h1, 4'h1};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    int   n;
    issue4(ta[0], tb[0], tc[0]);
    for (int i = 0; i < 3; i++) begin
      wait_done4(n);
      n_cmp++;
      if (done4 !== 1'b1 || n != 4) begin
        n_err++;
        $display("[TB] FAIL c1_latency[%0d]: done=%b after %0d edges, expected done=1 after 4", i, done4, n);
      end
      e = q4.pop_front();
      n_cmp++;
      if ({sum4, cout4, ovf4} !== {e.sum[3:0], e.cout, e.ovf}) begin
        n_err++;
        $display("[TB] FAIL c1_result[%0d]: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum4, cout4, ovf4, e.sum[3:0], e.cout, e.ovf);
      end
      if (i < 2) begin
        issue4(ta[i+1], tb[i+1], tc[i+1]);
        n_cmp++;
        if (done4 !== 1'b0 || busy4 !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL c1_accept[%0d]: done=%b busy=%b expected 0 1", i, done4, busy4);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef ADDER_SUB_EN
    sub8 = 1'b0;
    sub4 = 1'b0;
`endif
    #2;
    test_reset();
    test_add();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_chunk1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
